crc_frame_ctrl: RTL

Sequencer for the 32-bit-in / 10-bit-out CRC engine (CRCCYC). It accepts a frame of N 32-bit words over a valid/ready stream and clears the engine at frame start. It feeds one word per accepted beat, waits out the engine latency, then captures the 10-bit result. In check mode it compares the result against an expected value and reports done/error.

---
 rtl/crc_frame_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the CRCCYC engine: clears the engine, streams N words into it, then captures and checks the CRC.
// Optional idle-input watchdog is built in when CRC_TIMEOUT_EN is defined.
module crc_frame_ctrl #(
    parameter int FRAME_LEN_W = 8,
    parameter int CRC_LAT     = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   Clock,
    input  logic                   Rst_n,
    input  logic                   Frame_Start,
    input  logic [FRAME_LEN_W-1:0] Frame_Len,
    input  logic                   Check_Mode,
    input  logic [9:0]             Exp_Crc,
    input  logic                   Frame_Abort,
    input  logic                   Data_Valid,
    input  logic [31:0]            Data_In,
    output logic                   Data_Ready,
    output logic [31:0]            Crc_Data,
    output logic                   Crc_En,
    output logic                   Crc_Clr,
    input  logic [9:0]             Crc_Result,
    output logic [9:0]             Crc_Value,
    output logic                   Crc_Error,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Timeout
);

    localparam int LAT_W = $clog2(CRC_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [FRAME_LEN_W-1:0] word_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic                   check_q;
    logic [9:0]             exp_q;
    logic                   start_ok;
    logic                   beat;
    logic                   last_beat;
    logic                   capture;
    logic                   timeout_hit;

    assign start_ok  = (state == IDLE) && Frame_Start && (Frame_Len != '0);
    // An abort suppresses the coincident beat so the engine never sees a partial update.
    assign beat      = (state == FEED) && Data_Valid && !Frame_Abort;
    assign last_beat = beat && (word_cnt == FRAME_LEN_W'(1));
    assign capture   = (state == WAIT) && (lat_cnt == LAT_W'(1)) && !Frame_Abort;
    assign Crc_En    = beat;
    assign Crc_Data  = beat ? Data_In : 32'h0;

`ifdef CRC_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = (state == FEED) && !Data_Valid && !Frame_Abort &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    // Held at zero outside FEED, so entering FEED always starts a fresh idle count.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            idle_cnt <= '0;
        end else if (state != FEED || Data_Valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = CLEAR;
            CLEAR:   state_nxt = FEED;
            FEED: begin
                if (last_beat)        state_nxt = WAIT;
                else if (timeout_hit) state_nxt = IDLE;
            end
            WAIT:    if (lat_cnt == LAT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Frame_Abort && state != IDLE) state_nxt = IDLE;
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Crc_Clr    <= 1'b0;
            Data_Ready <= 1'b0;
            Timeout    <= 1'b0;
            word_cnt   <= '0;
            lat_cnt    <= '0;
            check_q    <= 1'b0;
            exp_q      <= 10'h000;
            Crc_Value  <= 10'h000;
            Crc_Error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            Busy       <= (state_nxt != IDLE);
            Done       <= (state_nxt == DONE);
            Crc_Clr    <= (state_nxt == CLEAR);
            Data_Ready <= (state_nxt == FEED);
            Timeout    <= timeout_hit;

            if (start_ok) begin
                word_cnt  <= Frame_Len;
                check_q   <= Check_Mode;
                exp_q     <= Exp_Crc;
                Crc_Error <= 1'b0;
            end else if (beat && word_cnt != '0) begin
                word_cnt <= word_cnt - 1'b1;
            end

            if (last_beat) begin
                lat_cnt <= LAT_W'(CRC_LAT);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (capture) begin
                Crc_Value <= Crc_Result;
                Crc_Error <= check_q && (Crc_Result != exp_q);
            end
        end
    end

endmodule
